// File: rtl/dmem_bus_ctrl.sv
// Data-memory bus controller: runs one req/ack bus transaction per MEM-stage access,
// builds byte enables / replicated store data and extends load data. Option: DMEM_MISALIGN_TRAP_EN.
module dmem_bus_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_req_i,
  input  logic                  data_we_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [2:0]            funct3_i,
  output logic                  stall_o,
  output logic [DATA_WIDTH-1:0] load_data_o,
  output logic                  load_valid_o,
  output logic                  bus_err_o,
  output logic                  misalign_o,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [3:0]            bus_be_o,
  output logic [DATA_WIDTH-1:0] bus_wdata_o,
  input  logic                  bus_ack_i,
  input  logic [DATA_WIDTH-1:0] bus_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] load_data_q, load_data_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic                  mis_q, mis_d;

  logic [3:0]            in_be;
  logic [DATA_WIDTH-1:0] in_wdata;
  logic                  in_mis;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [DATA_WIDTH-1:0] rdata_ext;

  // funct3[1:0]: 00 byte, 01 half, anything else is handled as a word.
  always_comb begin
    in_be    = 4'b1111;
    in_wdata = data_i;
    case (funct3_i[1:0])
      2'b00: begin
        in_be    = 4'b0001 << data_addr_i[1:0];
        in_wdata = {4{data_i[7:0]}};
      end
      2'b01: begin
        in_be    = data_addr_i[1] ? 4'b1100 : 4'b0011;
        in_wdata = {2{data_i[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign in_mis = ((funct3_i[1:0] == 2'b01) && data_addr_i[0]) ||
                  (funct3_i[1] && (data_addr_i[1:0] != 2'b00));
`else
  assign in_mis = 1'b0;
`endif

  always_comb begin
    byte_sel  = bus_rdata_i[{addr_q[1:0], 3'b000} +: 8];
    half_sel  = bus_rdata_i[{addr_q[1], 4'b0000} +: 16];
    rdata_ext = bus_rdata_i;
    case (funct3_q[1:0])
      2'b00:   rdata_ext = {{24{~funct3_q[2] & byte_sel[7]}}, byte_sel};
      2'b01:   rdata_ext = {{16{~funct3_q[2] & half_sel[15]}}, half_sel};
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    funct3_d    = funct3_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    cnt_d       = cnt_q;
    load_data_d = load_data_q;
    valid_d     = valid_q;
    err_d       = err_q;
    mis_d       = mis_q;
    case (state_q)
      IDLE: begin
        if (mem_req_i) begin
          we_d     = data_we_i;
          addr_d   = data_addr_i;
          funct3_d = funct3_i;
          wdata_d  = in_wdata;
          be_d     = in_be;
          cnt_d    = '0;
          valid_d  = 1'b0;
          err_d    = 1'b0;
          mis_d    = in_mis;
          state_d  = in_mis ? DONE : REQ;
        end
      end
      REQ: begin
        // Ack wins over a timeout landing in the same cycle.
        if (bus_ack_i) begin
          if (!we_q) begin
            load_data_d = rdata_ext;
            valid_d     = 1'b1;
          end
          state_d = DONE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          err_d       = 1'b1;
          load_data_d = '0;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      funct3_q    <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      cnt_q       <= '0;
      load_data_q <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      funct3_q    <= funct3_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      cnt_q       <= cnt_d;
      load_data_q <= load_data_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      mis_q       <= mis_d;
    end
  end

  // stall_o is gated by rst so that every output reads 0 while reset is held.
  assign stall_o      = ~rst & (((state_q == IDLE) & mem_req_i) | (state_q == REQ));
  assign bus_req_o    = (state_q == REQ);
  assign bus_we_o     = bus_req_o & we_q;
  assign bus_addr_o   = bus_req_o ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign bus_be_o     = bus_req_o ? be_q : 4'b0000;
  assign bus_wdata_o  = bus_req_o ? wdata_q : '0;
  assign load_valid_o = (state_q == DONE) & valid_q;
  assign bus_err_o    = (state_q == DONE) & err_q;
  assign misalign_o   = (state_q == DONE) & mis_q;
  assign load_data_o  = load_data_q;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Randomized bench for dmem_bus_ctrl: the bench acts as core and wait-stated bus,
// and checks each access against an arithmetic model of lanes, extension and latency.
module tb_dmem_bus_ctrl;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_i, data_we_i;
  logic [31:0] data_addr_i, data_i;
  logic [2:0]  funct3_i;
  logic        stall_o, load_valid_o, bus_err_o, misalign_o;
  logic [31:0] load_data_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_ld = 32'h0;

  always #5 clk = ~clk;

  dmem_bus_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .mem_req_i(mem_req_i), .data_we_i(data_we_i),
    .data_addr_i(data_addr_i), .data_i(data_i), .funct3_i(funct3_i),
    .stall_o(stall_o), .load_data_o(load_data_o), .load_valid_o(load_valid_o),
    .bus_err_o(bus_err_o), .misalign_o(misalign_o), .bus_req_o(bus_req_o),
    .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o),
    .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic int lane_base(input logic [31:0] addr, input logic [2:0] f3);
    int sz = size_of(f3);
    int off = int'(addr % 4);
    return (off / sz) * sz;
  endfunction

  function automatic logic [3:0] m_be(input logic [31:0] addr, input logic [2:0] f3);
    int sz = size_of(f3);
    int v = ((1 << sz) - 1) << lane_base(addr, f3);
    return 4'(v);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] data, input logic [2:0] f3);
    int sz = size_of(f3);
    if (sz == 1) return (data % 256) * 32'h01010101;
    if (sz == 2) return (data % 65536) * 32'h00010001;
    return data;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rdata, input logic [31:0] addr,
                                         input logic [2:0] f3);
    int     sz = size_of(f3);
    longint full = longint'(1) << (8 * sz);
    longint v = (longint'(rdata) >> (8 * lane_base(addr, f3))) % full;
    if (!f3[2] && sz < 4 && v >= full / 2) v = v - full;
    return 32'(v);
  endfunction

  function automatic logic m_mis(input logic [31:0] addr, input logic [2:0] f3);
`ifdef DMEM_MISALIGN_TRAP_EN
    int sz = size_of(f3);
    return (sz > 1) && (addr % sz != 0);
`else
    return (addr === 32'hx) && (f3 === 3'bx);
`endif
  endfunction

  // Starts at an IDLE cycle (just after a negedge) and returns at the next IDLE cycle.
  task automatic run_access(input string tag, input logic we, input logic [31:0] addr,
                            input logic [31:0] data, input logic [2:0] f3, input int delay,
                            input logic [31:0] rdata);
    logic mis, acked;
    int   stall_cnt, req_cnt, cyc;
    bit   done;
    mis       = m_mis(addr, f3);
    acked     = !mis && (delay < TMO);
    stall_cnt = 0;
    req_cnt   = 0;
    cyc       = 0;
    done      = 0;
    mem_req_i = 1'b1; data_we_i = we; data_addr_i = addr; data_i = data; funct3_i = f3;
    #1;
    while (!done && cyc < 300) begin
      if (stall_o) stall_cnt++;
      bus_ack_i   = 1'b0;
      bus_rdata_i = $urandom;
      if (bus_req_o) begin
        if (req_cnt == 0) begin
          check_eq({tag, ":addr"}, bus_addr_o, addr & 32'hFFFF_FFFC);
          check_eq({tag, ":be"}, {28'h0, bus_be_o}, {28'h0, m_be(addr, f3)});
          check_eq({tag, ":we"}, {31'h0, bus_we_o}, {31'h0, we});
          if (we) check_eq({tag, ":wdata"}, bus_wdata_o, m_wdata(data, f3));
        end
        if (req_cnt == delay) begin
          bus_ack_i   = 1'b1;
          bus_rdata_i = rdata;
        end
        req_cnt++;
      end
      if (cyc > 0 && !stall_o) begin
        done = 1;
        if (acked && !we) exp_ld = m_load(rdata, addr, f3);
        else if (!mis && !acked) exp_ld = 32'h0;
        check_eq({tag, ":valid"}, {31'h0, load_valid_o}, {31'h0, acked && !we});
        check_eq({tag, ":err"}, {31'h0, bus_err_o}, {31'h0, !mis && !acked});
        check_eq({tag, ":mis"}, {31'h0, misalign_o}, {31'h0, mis});
        check_eq({tag, ":ldata"}, load_data_o, exp_ld);
        mem_req_i = 1'b0;
      end else if (cyc > 0 && $urandom_range(0, 1) == 1) begin
        mem_req_i = 1'b0;
      end
      cyc++;
      @(negedge clk); #1;
    end
    check_eq({tag, ":retired"}, {31'h0, done}, 32'h1);
    check_eq({tag, ":stall_cycles"}, stall_cnt, mis ? 1 : (acked ? delay + 2 : TMO + 1));
    check_eq({tag, ":req_cycles"}, req_cnt, mis ? 0 : (acked ? delay + 1 : TMO));
    bus_ack_i = 1'b0;
    check_eq({tag, ":post_pulses"}, {29'h0, load_valid_o, bus_err_o, misalign_o}, 32'h0);
    check_eq({tag, ":post_stall"}, {30'h0, stall_o, bus_req_o}, 32'h0);
    check_eq({tag, ":hold_ldata"}, load_data_o, exp_ld);
    $display("txn %s we=%0d addr=0x%08h f3=%03b delay=%0d ldata=0x%08h stall=%0d",
             tag, we, addr, f3, delay, load_data_o, stall_cnt);
  endtask

  task automatic reset_during_req();
    mem_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h300; data_i = 32'h0; funct3_i = 3'b010;
    bus_ack_i = 1'b0;
    #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    check_eq("rst:req_before", {31'h0, bus_req_o}, 32'h1);
    rst = 1'b1;
    #1;
    check_eq("rst:req_drop", {31'h0, bus_req_o}, 32'h0);
    check_eq("rst:stall_drop", {31'h0, stall_o}, 32'h0);
    exp_ld = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    mem_req_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("rst:no_pulse", {29'h0, load_valid_o, bus_err_o, misalign_o}, 32'h0);
      check_eq("rst:idle", {30'h0, stall_o, bus_req_o}, 32'h0);
      check_eq("rst:ldata", load_data_o, exp_ld);
      @(negedge clk);
    end
    #1;
    $display("txn reset_during_req");
  endtask

  initial begin
    logic [2:0]  f3_tab [8];
    logic [31:0] a;
    int          d;
    f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    rst = 1'b1; mem_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h0; data_i = 32'h0;
    funct3_i = 3'b010; bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    @(negedge clk); #1;
    check_eq("reset:outs", {26'h0, stall_o, load_valid_o, bus_err_o, misalign_o, bus_req_o, bus_we_o}, 32'h0);
    check_eq("reset:ldata", load_data_o, 32'h0);
    check_eq("reset:bus", bus_addr_o | bus_wdata_o | {28'h0, bus_be_o}, 32'h0);
    mem_req_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;

    run_access("sw",       1'b1, 32'h100, 32'hDEADBEEF, 3'b010, 0,  32'h0);
    run_access("sb",       1'b1, 32'h103, 32'h000000A5, 3'b000, 1,  32'h0);
    run_access("lb",       1'b0, 32'h202, 32'h0,        3'b000, 3,  32'h1180FF22);
    run_access("lbu",      1'b0, 32'h202, 32'h0,        3'b100, 3,  32'h1180FF22);
    run_access("lhu",      1'b0, 32'h206, 32'h0,        3'b101, 0,  32'h80011234);
    run_access("lh",       1'b0, 32'h204, 32'h0,        3'b001, 2,  32'h1234F00D);
    run_access("ld_tmo",   1'b0, 32'h208, 32'h0,        3'b010, 99, 32'h0);
    run_access("lw_after", 1'b0, 32'h20C, 32'h0,        3'b010, 1,  32'hCAFEF00D);
    run_access("st_keep",  1'b1, 32'h210, 32'h12345678, 3'b001, 2,  32'h0);
    run_access("lw_mis",   1'b0, 32'h102, 32'h0,        3'b010, 0,  32'h89ABCDEF);
    reset_during_req();

    for (int n = 0; n < 60; n++) begin
      a = $urandom;
      d = ($urandom_range(0, 5) == 5) ? 99 : int'($urandom_range(0, 3));
      run_access($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), a, $urandom,
                 f3_tab[$urandom_range(0, 7)], d, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=0x%08h exp=0x%08h", checks, 0);
    $fatal(1, "watchdog expired");
  end

endmodule
